// File: rtl/aes_pkg.sv
// AES-128 shared definitions: controller state encoding, round count,
// rcon schedule, and the GF(2^8) helpers used by the round datapath and
// the on-the-fly key expansion (S-box, xtime, MixColumns column, SubWord,
// RotWord). No ports; imported by the controller and the round logic.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NR = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box computed rather than tabulated: inverse as a^254 (bits 1..7 of
  // the exponent are set, so every square except a^1 is multiplied in;
  // 0 maps to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = col;
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes128_iter_ctrl_if.sv
// Block handshake bundle for the iterative AES-128 controller.
//   in_valid/in_ready/in_block/in_key : plaintext + key input handshake
//   out_valid/out_ready/out_block     : ciphertext output handshake
// master = producer/consumer side, slave = the controller.
interface aes128_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped when last_round) -> AddRoundKey.
//   state_in   : current 128-bit state, byte 0 in [127:120]
//   rkey       : round key for this round
//   last_round : high in the tenth round (no MixColumns)
//   state_out  : state after the round
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_b;
  logic [127:0] shift_r;

  always_comb begin
    sub_b     = '0;
    shift_r   = '0;
    state_out = '0;
    for (int i = 0; i < 16; i++)
      sub_b[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
    // Byte index is row + 4*col; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shift_r[127-8*(r+4*c) -: 8] = sub_b[127-8*(r+4*((c+r)%4)) -: 8];
    for (int c = 0; c < 4; c++)
      state_out[127-32*c -: 32] =
        (last_round ? shift_r[127-32*c -: 32] : mix_column(shift_r[127-32*c -: 32]))
        ^ rkey[127-32*c -: 32];
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a
// shared round datapath, key schedule expanded on the fly.
//   clk, rst : clock, synchronous active-high reset
//   bus      : input (plaintext/key) and output (ciphertext) handshakes
//   busy     : high while rounds are running (ROUND or FINAL)
//   round    : current round index, 0 in IDLE/DONE
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  aes128_iter_ctrl_if.slave       bus,
  output logic                    busy,
  output logic [3:0]              round
);

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   round_q;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic [31:0]  key_t;
  logic [31:0]  w0, w1, w2, w3;

  // Next round key from the current one; rcon indexed by the round about to run.
  always_comb begin
    key_t   = sub_word(rot_word(rk_reg[31:0])) ^ {rcon(round_q), 24'h000000};
    w0      = rk_reg[127:96] ^ key_t;
    w1      = rk_reg[95:64]  ^ w0;
    w2      = rk_reg[63:32]  ^ w1;
    w3      = rk_reg[31:0]   ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  aes_round_comb u_round (
    .state_in   (state_reg),
    .rkey       (rk_next),
    .last_round (state_q == ST_FINAL),
    .state_out  (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = ST_ROUND;
      ST_ROUND: if (round_q == NR - 4'd1) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // All handshake outputs decode registered state only.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    busy          = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    round         = round_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q       <= 4'd0;
      state_reg     <= '0;
      rk_reg        <= '0;
      bus.out_block <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.in_block ^ bus.in_key;
            rk_reg    <= bus.in_key;
            round_q   <= 4'd1;
          end
        end
        ST_ROUND: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          round_q   <= round_q + 4'd1;
        end
        ST_FINAL: begin
          state_reg     <= round_out;
          rk_reg        <= rk_next;
          bus.out_block <= round_out;
          round_q       <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl: FIPS-197 vectors, latency,
// backpressure, input isolation, mid-operation reset and back-to-back flow.
module tb_aes128_iter_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [3:0] round;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  aes128_iter_ctrl_if bus ();

  aes128_iter_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .busy  (busy),
    .round (round)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference AES-128: byte-matrix formulation with a full precomputed schedule.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [15:0] poly;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) begin
        poly = 16'h011b << (i - 8);
        p    = p ^ poly;
      end
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h00;
    c   = 8'h63;
    for (int b = 1; b < 256; b++)
      if (ref_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0]),
               ref_sbox(tmp[31:24])} ^ {rc, 24'h000000};
        rc  = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = ref_sbox(s[i]);
      for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r != 10) begin
          s[4*c]   = ref_mul(t[4*c], 8'h02) ^ ref_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ ref_mul(t[4*c+1], 8'h02) ^ ref_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ ref_mul(t[4*c+2], 8'h02) ^ ref_mul(t[4*c+3], 8'h03);
          s[4*c+3] = ref_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ ref_mul(t[4*c+3], 8'h02);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Present a block and return at #1 after the accepting edge with in_valid low.
  task automatic accept(input string tag, input logic [127:0] pt, input logic [127:0] key);
    int k;
    bus.in_valid = 1'b1;
    bus.in_block = pt;
    bus.in_key   = key;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_ready"}, 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen (bounded).
  task automatic wait_out(input string tag, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(1));
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int           lat;
    int           cnt;
    logic         stable_v, stable_b, stable_r;
    logic [127:0] held;
    logic [127:0] vpt [4];
    logic [127:0] vkey [4];
    logic [127:0] vexp [4];
    logic         acc, hs;
    logic [127:0] ob;
    int           idx, nres, low;

    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(busy),          128'(0));
    chk("rst_round",     128'(round),         128'(0));
    chk("rst_out_block", bus.out_block,       128'(0));
    chk("rst_state_reg", dut.state_reg,       128'(0));
    chk("rst_rk_reg",    dut.rk_reg,          128'(0));
    rst = 1'b0;
    step();

    // FIPS-197 C.1 with latency
    accept("c1", C1_PT, C1_KEY);
    chk("c1_busy",   128'(busy),  128'(1));
    chk("c1_round1", 128'(round), 128'(1));
    wait_out("c1", lat);
    chk("c1_latency", 128'(lat), 128'(10));
    chk("c1_ct", bus.out_block, C1_CT);
    chk("c1_done_round", 128'(round), 128'(0));
    chk("c1_done_busy", 128'(busy), 128'(0));
    handshake();
    chk("c1_back_idle", 128'(bus.in_ready), 128'(1));

    // FIPS-197 Appendix B with round-1 intermediate, then backpressure
    accept("appb", B_PT, B_KEY);
    step();
    chk("appb_round1_state", dut.state_reg, B_R1);
    chk("appb_round2", 128'(round), 128'(2));
    wait_out("appb", lat);
    chk("appb_latency_after_r1", 128'(lat), 128'(9));
    chk("appb_ct", bus.out_block, B_CT);
    held = bus.out_block;
    stable_v = 1'b1;
    stable_b = 1'b1;
    stable_r = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.out_valid !== 1'b1) stable_v = 1'b0;
      if (bus.out_block !== held) stable_b = 1'b0;
      if (bus.in_ready !== 1'b0) stable_r = 1'b0;
    end
    chk("bp_out_valid_held", 128'(stable_v), 128'(1));
    chk("bp_out_block_held", 128'(stable_b), 128'(1));
    chk("bp_in_ready_low",   128'(stable_r), 128'(1));
    handshake();
    chk("bp_release_in_ready",  128'(bus.in_ready),  128'(1));
    chk("bp_release_out_valid", 128'(bus.out_valid), 128'(0));

    // Input change during rounds has no effect; held in_valid accepted only in IDLE
    bus.in_valid = 1'b1;
    bus.in_block = C1_PT;
    bus.in_key   = C1_KEY;
    step();
    bus.in_block = '1;
    bus.in_key   = '1;
    chk("chg_in_ready_low", 128'(bus.in_ready), 128'(0));
    wait_out("chg", lat);
    chk("chg_latency", 128'(lat), 128'(10));
    chk("chg_c1_ct", bus.out_block, C1_CT);
    handshake();
    chk("chg_idle", 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
    chk("chg_second_round1", 128'(round), 128'(1));
    wait_out("chg2", lat);
    chk("chg2_latency", 128'(lat), 128'(10));
    chk("chg2_ct", bus.out_block, aes_ref('1, '1));
    handshake();

    // Reset at round 5 discards the block
    accept("rmid", C1_PT, C1_KEY);
    for (int k = 0; k < 4; k++) step();
    chk("rmid_round5", 128'(round), 128'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_state_idle", 128'(dut.state_q), 128'(ST_IDLE));
    chk("rmid_round",      128'(round),          128'(0));
    chk("rmid_out_valid",  128'(bus.out_valid),  128'(0));
    chk("rmid_busy",       128'(busy),           128'(0));
    chk("rmid_in_ready",   128'(bus.in_ready),   128'(1));
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.out_valid) cnt++;
    end
    chk("rmid_no_stale_output", 128'(cnt), 128'(0));
    accept("rmid_fresh", C1_PT, C1_KEY);
    wait_out("rmid_fresh", lat);
    chk("rmid_fresh_latency", 128'(lat), 128'(10));
    chk("rmid_fresh_ct", bus.out_block, C1_CT);
    handshake();

    // Back-to-back with out_ready held high. Between accepts in_ready is low
    // for 11 cycles (10 processing edges plus the DONE handshake edge).
    for (int i = 0; i < 4; i++) begin
      vpt[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vkey[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      vexp[i] = aes_ref(vpt[i], vkey[i]);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_block  = vpt[0];
    bus.in_key    = vkey[0];
    idx  = 0;
    nres = 0;
    low  = 0;
    for (int cyc = 0; cyc < 200 && nres < 4; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      ob  = bus.out_block;
      if (!bus.in_ready && idx > 0 && idx < 4) low++;
      step();
      if (hs) begin
        chk($sformatf("b2b_ct%0d", nres), ob, vexp[nres]);
        nres++;
      end
      if (acc) begin
        if (idx > 0) begin
          chk($sformatf("b2b_gap%0d", idx), 128'(low), 128'(11));
          low = 0;
        end
        idx++;
        if (idx < 4) begin
          bus.in_block = vpt[idx];
          bus.in_key   = vkey[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", 128'(nres), 128'(4));
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
